// File: rtl/seg7_phase_driver.sv
// Phase-driven 3-digit common-anode 7-segment driver.
// Blanks on every phase change, commits buffered digits, flags bad phases.
module seg7_phase_driver #(
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZB       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1,
  input  logic        ph2,
  input  logic        ph3,
  input  logic        load,
  input  logic [11:0] digits,
  input  logic [2:0]  dp,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] RELOAD = 8'(BLANK_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  pd_q;
  logic [2:0]  psel_q, psel_d;
  logic [14:0] shd_q, shd_d;
  logic [14:0] act_q, act_d;
  logic        err_q, err_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpn_q, dpn_d;

  logic [2:0]  p;
  logic        chg;
  logic [14:0] ld_val;

  assign p      = {ph3, ph2, ph1};
  assign chg    = (p != pd_q);
  assign ld_val = {digits, dp};

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psel_d  = psel_q;
    act_d   = act_q;
    err_d   = err_q;
    shd_d   = load ? ld_val : shd_q;
    if (chg) begin
      // Commit point: a same-cycle load bypasses shadow
      state_d = BLANK;
      cnt_d   = RELOAD;
      psel_d  = p;
      act_d   = load ? ld_val : shd_q;
    end else if (state_q == BLANK) begin
      if (cnt_q == 8'd0) begin
        if ($onehot(psel_q)) begin
          state_d = SHOW;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  logic [3:0] d0, d1, d2;
  logic [3:0] dsel;
  logic       dpsel;
  logic       blk;

  assign d0 = act_d[6:3];
  assign d1 = act_d[10:7];
  assign d2 = act_d[14:11];

  always_comb begin
    dsel  = d0;
    dpsel = act_d[0];
    blk   = 1'b0;
    case (psel_d)
      3'b010: begin
        dsel  = d1;
        dpsel = act_d[1];
        blk   = LZB && (d2 == 4'd0) && (d1 == 4'd0);
      end
      3'b100: begin
        dsel  = d2;
        dpsel = act_d[2];
        blk   = LZB && (d2 == 4'd0);
      end
      default: begin
        dsel  = d0;
        dpsel = act_d[0];
        blk   = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_d  = 3'b111;
    seg_d = 7'b1111111;
    dpn_d = 1'b1;
    if (state_d == SHOW) begin
      an_d  = ~psel_d;
      seg_d = blk ? 7'b1111111 : dec(dsel);
      dpn_d = ~dpsel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pd_q    <= 3'b000;
      psel_q  <= 3'b000;
      shd_q   <= '0;
      act_q   <= '0;
      err_q   <= 1'b0;
      an_q    <= 3'b111;
      seg_q   <= 7'b1111111;
      dpn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pd_q    <= p;
      psel_q  <= psel_d;
      shd_q   <= shd_d;
      act_q   <= act_d;
      err_q   <= err_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dpn_q;
  assign err  = err_q;

endmodule

// File: tb/tb_seg7_phase_driver.sv
// Bench for seg7_phase_driver: cycle-level event model, LZB=1 and LZB=0.
// Directed plan steps followed by randomized phase/load traffic.
module tb_seg7_phase_driver;

  localparam int BC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ph1, ph2, ph3;
  logic        load;
  logic [11:0] digits;
  logic [2:0]  dp;
  logic [2:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dpn0, dpn1;
  logic        err0, err1;

  int nasrt = 0;
  int nfail = 0;
  int blank_cnt = 0;

  always #5 clk = ~clk;

  seg7_phase_driver #(.BLANK_CYC(BC), .LZB(1'b1)) u0 (
    .clk(clk), .rst(rst), .ph1(ph1), .ph2(ph2), .ph3(ph3),
    .load(load), .digits(digits), .dp(dp),
    .an(an0), .seg(seg0), .dp_n(dpn0), .err(err0)
  );

  seg7_phase_driver #(.BLANK_CYC(BC), .LZB(1'b0)) u1 (
    .clk(clk), .rst(rst), .ph1(ph1), .ph2(ph2), .ph3(ph3),
    .load(load), .digits(digits), .dp(dp),
    .an(an1), .seg(seg1), .dp_n(dpn1), .err(err1)
  );

  logic [6:0] tbl [16];
  initial begin
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30;
    tbl[4] = 7'h19; tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78;
    tbl[8] = 7'h00; tbl[9] = 7'h10;
    for (int k = 10; k < 16; k++) tbl[k] = 7'h3F;
  end

  // Model: time since last change, committed value, selected phase
  logic [2:0]  m_pd;
  logic [2:0]  m_psel;
  logic [14:0] m_sh, m_act;
  bit          m_seen;
  bit          m_err;
  int          m_since;

  task automatic model_edge();
    logic [2:0] pv;
    if (rst) begin
      m_pd = 0; m_psel = 0; m_sh = 0; m_act = 0;
      m_seen = 0; m_err = 0; m_since = 0;
    end else begin
      pv = {ph3, ph2, ph1};
      if (pv != m_pd) begin
        m_seen  = 1;
        m_since = 0;
        m_psel  = pv;
        m_act   = load ? {digits, dp} : m_sh;
      end else if (m_seen && m_since < 100000) begin
        m_since++;
      end
      if (m_seen && m_since == BC && !$onehot(m_psel)) m_err = 1;
      if (load) m_sh = {digits, dp};
      m_pd = pv;
    end
  endtask

  function automatic int sel_idx(input logic [2:0] ps);
    return ps[2] ? 2 : (ps[1] ? 1 : 0);
  endfunction

  function automatic bit showing();
    return m_seen && m_since >= BC && $onehot(m_psel);
  endfunction

  function automatic logic [6:0] exp_seg(input bit lzb);
    int i;
    logic [3:0] d, dh, dm;
    bit b;
    if (!showing()) return 7'h7F;
    i  = sel_idx(m_psel);
    d  = m_act[3 + 4 * i +: 4];
    dm = m_act[10:7];
    dh = m_act[14:11];
    b  = lzb && ((i == 2 && dh == 0) || (i == 1 && dh == 0 && dm == 0));
    return b ? 7'h7F : tbl[d];
  endfunction

  function automatic logic exp_dpn();
    if (!showing()) return 1'b1;
    return ~m_act[sel_idx(m_psel)];
  endfunction

  function automatic logic [2:0] exp_an();
    return showing() ? ~m_psel : 3'b111;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (an0 === 3'b111) blank_cnt++;
    chk("an0", {13'b0, an0}, {13'b0, exp_an()});
    chk("seg0", {9'b0, seg0}, {9'b0, exp_seg(1'b1)});
    chk("dpn0", {15'b0, dpn0}, {15'b0, exp_dpn()});
    chk("err0", {15'b0, err0}, {15'b0, m_err});
    chk("an1", {13'b0, an1}, {13'b0, exp_an()});
    chk("seg1", {9'b0, seg1}, {9'b0, exp_seg(1'b0)});
    chk("dpn1", {15'b0, dpn1}, {15'b0, exp_dpn()});
    chk("err1", {15'b0, err1}, {15'b0, m_err});
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic setp(input logic [2:0] v);
    {ph3, ph2, ph1} = v;
  endtask

  task automatic do_load(input logic [11:0] d, input logic [2:0] p);
    digits = d; dp = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  logic [2:0] seq [3];
  logic [6:0] exp0 [3];

  initial begin
    rst = 1'b1; load = 1'b0; digits = 0; dp = 0;
    setp(3'b000);
    hold(2);
    chk("rst_an", {13'b0, an0}, 16'h0007);
    chk("rst_seg", {9'b0, seg0}, 16'h007F);
    chk("rst_dpn", {15'b0, dpn0}, 16'h0001);
    chk("rst_err", {15'b0, err0}, 16'h0000);
    rst = 1'b0;
    hold(3);

    setp(3'b001);
    do_load(12'h123, 3'b000);
    hold(BC + 4);
    chk("d0_an", {13'b0, an0}, 16'h0006);
    chk("d0_seg3", {9'b0, seg0}, 16'h0030);

    do_load(12'h407, 3'b000);
    hold(5);
    seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001;
    exp0[0] = 7'h40; exp0[1] = 7'h19; exp0[2] = 7'h78;
    for (int k = 0; k < 3; k++) begin
      setp(seq[k]);
      blank_cnt = 0;
      hold(40);
      chk("blank16", 16'(blank_cnt), 16'd16);
      chk("cyc_seg", {9'b0, seg0}, {9'b0, exp0[k]});
    end

    do_load(12'h005, 3'b000);
    setp(3'b010); hold(BC + 3);
    chk("lzb1_seg", {9'b0, seg0}, 16'h007F);
    chk("lzb1_an", {13'b0, an0}, 16'h0005);
    chk("nolzb1", {9'b0, seg1}, 16'h0040);
    setp(3'b100); hold(BC + 3);
    chk("lzb2_seg", {9'b0, seg0}, 16'h007F);
    chk("nolzb2", {9'b0, seg1}, 16'h0040);
    setp(3'b001); hold(BC + 3);
    chk("lzb0_seg", {9'b0, seg0}, 16'h0012);

    do_load(12'h123, 3'b010);
    setp(3'b010); hold(BC + 3);
    setp(3'b001); hold(BC + 3);
    do_load(12'h999, 3'b111);
    hold(10);
    chk("noteart", {9'b0, seg0}, 16'h0030);
    setp(3'b010); hold(BC + 3);
    chk("commit9", {9'b0, seg0}, 16'h0010);
    chk("dp_lit", {15'b0, dpn0}, 16'h0000);

    setp(3'b011); hold(BC + 5);
    chk("bad_an", {13'b0, an0}, 16'h0007);
    chk("bad_err", {15'b0, err0}, 16'h0001);
    setp(3'b100); hold(BC + 5);
    chk("resume", {13'b0, an0}, 16'h0003);
    chk("sticky", {15'b0, err0}, 16'h0001);

    blank_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      setp((k % 2) ? 3'b001 : 3'b010);
      hold(5);
    end
    chk("fastblank", 16'(blank_cnt), 16'd40);

    setp(3'b100); hold(4);
    rst = 1'b1; step();
    chk("mrst_an", {13'b0, an0}, 16'h0007);
    chk("mrst_seg", {9'b0, seg0}, 16'h007F);
    chk("mrst_err", {15'b0, err0}, 16'h0000);
    rst = 1'b0;
    hold(BC + 3);
    chk("relchg", {13'b0, an0}, 16'h0003);

    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 5) == 0) setp(3'($urandom));
      else setp(3'b001 << $urandom_range(0, 2));
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        if ($urandom_range(0, 7) == 0) begin
          digits = 12'($urandom); dp = 3'($urandom); load = 1'b1;
        end
        step();
        load = 1'b0;
      end
      if ($urandom_range(0, 20) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
